// File: rtl/arisc_pkg.sv
// Shared types for the A-RISC second-generation core: opcodes, register map, FSM states, instruction layout.
package arisc_pkg;

   typedef enum logic [3:0] {
      OP_END = 4'd0,
      OP_ADD = 4'd1,
      OP_SUB = 4'd2,
      OP_MUL = 4'd3,
      OP_DV2 = 4'd4,
      OP_LDM = 4'd5,
      OP_STM = 4'd6,
      OP_MVR = 4'd7,
      OP_MVI = 4'd8,
      OP_BNE = 4'd9,
      OP_BLT = 4'd10
   } opcode_e;

   localparam logic [3:0] REG_ZERO = 4'd0;
   localparam logic [3:0] REG_ONE  = 4'd1;
   localparam logic [3:0] REG_DIN  = 4'd2;
   localparam logic [3:0] REG_IM   = 4'd3;
   localparam logic [3:0] REG_ADR  = 4'd4;
   localparam logic [3:0] REG_JAD  = 4'd5;
   localparam logic [3:0] REG_GPR0 = 4'd6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EXEC,
      ST_MEM
   } state_e;

   typedef struct packed {
      logic [3:0] rb;
      logic [3:0] ra;
      logic [3:0] rd;
      logic [3:0] opcode;
   } instr_t;

endpackage

// File: rtl/arisc_alu.sv
// Combinational A-RISC arithmetic unit (ADD/SUB/DV2, MUL only when ARISC_MUL_EN is defined).
// ok_o low means the opcode is not executable by this build of the ALU.
module arisc_alu
   import arisc_pkg::*;
#(
   parameter int unsigned W_DATA = 8
) (
   input  logic [3:0]        op_i,
   input  logic [W_DATA-1:0] a_i,
   input  logic [W_DATA-1:0] b_i,
   output logic [W_DATA-1:0] res_o,
   output logic              ok_o
);

   always_comb begin
      res_o = '0;
      ok_o  = 1'b1;
      case (op_i)
         OP_ADD: res_o = a_i + b_i;
         OP_SUB: res_o = a_i - b_i;
         // bias negatives by one before the arithmetic shift so the quotient rounds toward zero
         OP_DV2: res_o = W_DATA'($signed(a_i + W_DATA'(a_i[W_DATA-1])) >>> 1);
`ifdef ARISC_MUL_EN
         OP_MUL: res_o = a_i * b_i;
`endif
         default: ok_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/arisc_core.sv
// A-RISC second-generation core: IDLE/FETCH/EXEC/MEM sequencer, register file and data-memory handshake.
// Optional multiplier enabled by defining ARISC_MUL_EN (otherwise MUL is an illegal opcode).
module arisc_core
   import arisc_pkg::*;
#(
   parameter int unsigned W_DATA  = 8,
   parameter int unsigned W_ADDR  = 8,
   parameter int unsigned NUM_GPR = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              idle,
   output logic              illegal,
   output logic [W_ADDR-1:0] iram_addr,
   input  logic [15:0]       iram_dout,
   output logic              dram_req,
   output logic              dram_we,
   output logic [W_ADDR-1:0] dram_addr,
   output logic [W_DATA-1:0] dram_din,
   input  logic [W_DATA-1:0] dram_dout,
   input  logic              dram_ack
);

   state_e            state_q, state_d;
   logic [W_ADDR-1:0] pc_q, pc_d;
   logic [W_DATA-1:0] gpr_q [NUM_GPR];
   logic [W_DATA-1:0] gpr_d [NUM_GPR];
   logic [W_DATA-1:0] adr_q, adr_d, jad_q, jad_d, din_q, din_d;
   logic              illegal_q, illegal_d, req_q, req_d, we_q, we_d;
   logic [W_ADDR-1:0] maddr_q, maddr_d;
   logic [W_DATA-1:0] mdin_q, mdin_d;

   instr_t            ins;
   logic [W_DATA-1:0] im, ra_val, rb_val, alu_res, wr_data;
   logic              alu_ok, wr_en;
   logic [W_DATA-1:0] rf_view [16];

   assign ins = instr_t'(iram_dout);
   assign im  = W_DATA'($signed({ins.ra, ins.rb}));

   // full 16-entry read view; unimplemented addresses read as zero
   always_comb begin
      for (int unsigned k = 0; k < 16; k++) rf_view[k] = '0;
      rf_view[REG_ONE] = W_DATA'(1);
      rf_view[REG_DIN] = din_q;
      rf_view[REG_IM]  = im;
      rf_view[REG_ADR] = adr_q;
      rf_view[REG_JAD] = jad_q;
      for (int unsigned g = 0; g < NUM_GPR; g++) rf_view[32'(REG_GPR0) + g] = gpr_q[g];
   end

   assign ra_val = rf_view[ins.ra];
   assign rb_val = rf_view[ins.rb];

   arisc_alu #(.W_DATA(W_DATA)) u_alu (
      .op_i  (ins.opcode),
      .a_i   (ra_val),
      .b_i   (rb_val),
      .res_o (alu_res),
      .ok_o  (alu_ok)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      gpr_d     = gpr_q;
      adr_d     = adr_q;
      jad_d     = jad_q;
      din_d     = din_q;
      illegal_d = illegal_q;
      req_d     = req_q;
      we_d      = we_q;
      maddr_d   = maddr_q;
      mdin_d    = mdin_q;
      wr_en     = 1'b0;
      wr_data   = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_FETCH;
               pc_d      = '0;
               illegal_d = 1'b0;
            end
         end
         ST_FETCH: state_d = ST_EXEC;
         ST_EXEC: begin
            state_d = ST_FETCH;
            pc_d    = pc_q + W_ADDR'(1);
            case (ins.opcode)
               OP_END: begin
                  state_d = ST_IDLE;
                  pc_d    = '0;
               end
               OP_ADD, OP_SUB, OP_MUL, OP_DV2: begin
                  if (alu_ok) begin
                     wr_en   = 1'b1;
                     wr_data = alu_res;
                  end else begin
                     illegal_d = 1'b1;
                  end
               end
               OP_MVR: begin
                  wr_en   = 1'b1;
                  wr_data = ra_val;
               end
               OP_MVI: begin
                  wr_en   = 1'b1;
                  wr_data = im;
               end
               OP_BNE: if (ra_val != rb_val) pc_d = jad_q[W_ADDR-1:0];
               OP_BLT: if ($signed(ra_val) < $signed(rb_val)) pc_d = jad_q[W_ADDR-1:0];
               // pc is held so the instruction word stays valid throughout MEM
               OP_LDM, OP_STM: begin
                  state_d = ST_MEM;
                  pc_d    = pc_q;
                  req_d   = 1'b1;
                  we_d    = (ins.opcode == OP_STM);
                  maddr_d = adr_q[W_ADDR-1:0];
                  mdin_d  = ra_val;
               end
               default: illegal_d = 1'b1;
            endcase
         end
         ST_MEM: begin
            if (dram_ack) begin
               state_d = ST_FETCH;
               pc_d    = pc_q + W_ADDR'(1);
               req_d   = 1'b0;
               we_d    = 1'b0;
               if (!we_q) din_d = dram_dout;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (wr_en) begin
         if (ins.rd == REG_ADR) adr_d = wr_data;
         if (ins.rd == REG_JAD) jad_d = wr_data;
         for (int unsigned g = 0; g < NUM_GPR; g++) begin
            if (ins.rd == 4'(32'(REG_GPR0) + g)) gpr_d[g] = wr_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pc_q      <= '0;
         for (int unsigned g = 0; g < NUM_GPR; g++) gpr_q[g] <= '0;
         adr_q     <= '0;
         jad_q     <= '0;
         din_q     <= '0;
         illegal_q <= 1'b0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         maddr_q   <= '0;
         mdin_q    <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         gpr_q     <= gpr_d;
         adr_q     <= adr_d;
         jad_q     <= jad_d;
         din_q     <= din_d;
         illegal_q <= illegal_d;
         req_q     <= req_d;
         we_q      <= we_d;
         maddr_q   <= maddr_d;
         mdin_q    <= mdin_d;
      end
   end

   assign idle      = (state_q == ST_IDLE);
   assign illegal   = illegal_q;
   assign iram_addr = pc_q;
   assign dram_req  = req_q;
   assign dram_we   = we_q;
   assign dram_addr = maddr_q;
   assign dram_din  = mdin_q;

endmodule

// File: tb/tb_arisc_core.sv
// Scoreboard bench for arisc_core (W_DATA=16, W_ADDR=8): register values are observed through STM traffic.
module tb_arisc_core;
   import arisc_pkg::*;

   localparam int unsigned WD    = 16;
   localparam int unsigned WA    = 8;
   localparam int unsigned NEVER = 255;

   logic          clk = 1'b0;
   logic          rst, start, idle, illegal;
   logic [WA-1:0] iram_addr, dram_addr;
   logic [15:0]   iram_dout;
   logic          dram_req, dram_we, dram_ack, resp_ack, man_ack;
   logic [WD-1:0] dram_din, dram_dout;

   arisc_core #(.W_DATA(WD), .W_ADDR(WA), .NUM_GPR(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .idle      (idle),
      .illegal   (illegal),
      .iram_addr (iram_addr),
      .iram_dout (iram_dout),
      .dram_req  (dram_req),
      .dram_we   (dram_we),
      .dram_addr (dram_addr),
      .dram_din  (dram_din),
      .dram_dout (dram_dout),
      .dram_ack  (dram_ack)
   );

   always #5 clk = ~clk;

   logic [15:0] iram [256];
   always @(posedge clk) iram_dout <= iram[iram_addr];
   assign dram_ack = resp_ack | man_ack;

   typedef struct {
      logic          we;
      logic [WA-1:0] addr;
      logic [WD-1:0] data;
      bit            chk_data;
      int unsigned   req_cycles;
   } exp_t;

   exp_t        exp_q [$];
   int unsigned dly_q [$];
   int          n_err = 0;
   int          n_chk = 0;
   int unsigned wp;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] ra, input logic [3:0] rb);
      return {rb, ra, rd, op};
   endfunction

   function automatic logic [15:0] mvi(input logic [3:0] rd, input logic [7:0] imm);
      return {imm[3:0], imm[7:4], rd, 4'd8};
   endfunction

   task automatic clr();
      for (int i = 0; i < 256; i++) iram[i] = 16'h0000;
      wp = 0;
   endtask

   task automatic put(input logic [15:0] w);
      iram[wp] = w;
      wp++;
   endtask

   task automatic expect_mem(input logic we, input logic [WA-1:0] addr, input logic [WD-1:0] data,
                             input bit cd, input int unsigned dly);
      exp_t e;
      e.we = we; e.addr = addr; e.data = data; e.chk_data = cd; e.req_cycles = dly + 1;
      exp_q.push_back(e);
      dly_q.push_back(dly);
   endtask

   task automatic run(input int unsigned exp_cyc, input string nm);
      int unsigned cyc;
      cyc = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!idle && cyc < 200) begin
         cyc++;
         @(negedge clk);
      end
      chk({nm, "_cycles"}, cyc, exp_cyc);
      if (!idle) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
      end
   endtask

   // data-memory responder: acks after the queued number of wait cycles
   initial begin
      int unsigned cnt;
      bit          active;
      resp_ack = 1'b0;
      dram_dout = 16'h00A5;
      cnt = 0;
      active = 1'b0;
      forever begin
         @(negedge clk);
         if (resp_ack) begin
            resp_ack = 1'b0;
            active = 1'b0;
         end else if (dram_req) begin
            if (!active) begin
               active = 1'b1;
               cnt = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
            end
            if (cnt == 0) resp_ack = 1'b1;
            else if (cnt != NEVER) cnt--;
         end else begin
            active = 1'b0;
         end
      end
   end

   // monitor: compares each completed access against the scoreboard
   initial begin
      int unsigned rc;
      exp_t        e;
      rc = 0;
      forever begin
         @(negedge clk);
         #1;
         if (dram_req) begin
            rc++;
            if (dram_ack) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_err++;
                  $display("FAIL mem_unexpected: got we=%0b addr=%0h din=%0h expected no access",
                           dram_we, dram_addr, dram_din);
               end else begin
                  e = exp_q.pop_front();
                  chk("mem_we", dram_we, e.we);
                  chk("mem_addr", dram_addr, e.addr);
                  if (e.chk_data) chk("mem_din", dram_din, e.data);
                  chk("mem_req_cycles", rc, e.req_cycles);
               end
               rc = 0;
            end
         end else begin
            rc = 0;
         end
      end
   end

   initial begin
      int unsigned cyc;
      rst = 1'b1;
      start = 1'b0;
      man_ack = 1'b0;
      clr();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_idle", idle, 1'b1);
      chk("rst_illegal", illegal, 1'b0);
      chk("rst_req", dram_req, 1'b0);
      chk("rst_we", dram_we, 1'b0);
      chk("rst_pc", iram_addr, 0);
      chk("rst_addr", dram_addr, 0);
      chk("rst_din", dram_din, 0);

      // r8 = 5 + (-3)
      clr();
      put(mvi(4'd6, 8'h05));
      put(mvi(4'd7, 8'hFD));
      put(enc(4'd1, 4'd8, 4'd6, 4'd7));
      put(16'h0000);
      run(8, "add");
      chk("add_idle_pc", iram_addr, 0);
      chk("add_illegal", illegal, 1'b0);

      clr();
      put(mvi(4'd4, 8'h20));
      put(enc(4'd6, 4'd0, 4'd8, 4'd0));
      put(16'h0000);
      expect_mem(1'b1, 8'h20, 16'h0002, 1'b1, 0);
      run(7, "store_r8");

      // DV2 and MUL of -128
      clr();
      put(mvi(4'd6, 8'h80));
      put(enc(4'd4, 4'd7, 4'd6, 4'd0));
      put(enc(4'd3, 4'd8, 4'd6, 4'd6));
      put(mvi(4'd4, 8'h01));
      put(enc(4'd6, 4'd0, 4'd7, 4'd0));
      put(mvi(4'd4, 8'h02));
      put(enc(4'd6, 4'd0, 4'd8, 4'd0));
      put(16'h0000);
      expect_mem(1'b1, 8'h01, 16'hFFC0, 1'b1, 0);
`ifdef ARISC_MUL_EN
      expect_mem(1'b1, 8'h02, 16'h4000, 1'b1, 0);
      run(18, "dv2_mul");
      chk("mul_illegal", illegal, 1'b0);
`else
      expect_mem(1'b1, 8'h02, 16'h0002, 1'b1, 0);
      run(18, "dv2_mul");
      chk("mul_illegal", illegal, 1'b1);
`endif

      // store with 3 wait cycles, load with none, move DIN out
      clr();
      put(mvi(4'd4, 8'h10));
      put(mvi(4'd6, 8'h5A));
      put(enc(4'd6, 4'd0, 4'd6, 4'd0));
      put(enc(4'd5, 4'd0, 4'd0, 4'd0));
      put(enc(4'd7, 4'd7, 4'd2, 4'd0));
      put(mvi(4'd4, 8'h11));
      put(enc(4'd6, 4'd0, 4'd7, 4'd0));
      put(16'h0000);
      expect_mem(1'b1, 8'h10, 16'h005A, 1'b1, 3);
      expect_mem(1'b0, 8'h10, 16'h0000, 1'b0, 0);
      expect_mem(1'b1, 8'h11, 16'h00A5, 1'b1, 0);
      run(22, "mem_hs");
      chk("mem_illegal_cleared", illegal, 1'b0);

      // BLT taken skips the store at 0x30; BNE with equal operands falls through
      clr();
      put(mvi(4'd6, 8'h80));
      put(mvi(4'd7, 8'h01));
      put(mvi(4'd5, 8'h06));
      put(enc(4'd10, 4'd0, 4'd6, 4'd7));
      put(mvi(4'd4, 8'h30));
      put(enc(4'd6, 4'd0, 4'd6, 4'd0));
      put(enc(4'd9, 4'd0, 4'd7, 4'd7));
      put(mvi(4'd4, 8'h31));
      put(enc(4'd6, 4'd0, 4'd7, 4'd0));
      put(16'h0000);
      expect_mem(1'b1, 8'h31, 16'h0001, 1'b1, 0);
      run(17, "branch");

      // reset while waiting for an ack that never comes
      clr();
      put(mvi(4'd4, 8'h40));
      put(enc(4'd6, 4'd0, 4'd6, 4'd0));
      put(16'h0000);
      dly_q.push_back(NEVER);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!dram_req && cyc < 20) begin
         cyc++;
         @(negedge clk);
      end
      chk("rstmem_req_seen", dram_req, 1'b1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rstmem_idle", idle, 1'b1);
      chk("rstmem_req", dram_req, 1'b0);
      chk("rstmem_pc", iram_addr, 0);
      repeat (2) @(negedge clk);
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      @(negedge clk);
      chk("late_ack_idle", idle, 1'b1);
      chk("late_ack_req", dram_req, 1'b0);
      dly_q.delete();

      // restart from pc 0; r6 was cleared by the reset
      clr();
      put(mvi(4'd4, 8'h41));
      put(enc(4'd6, 4'd0, 4'd6, 4'd0));
      put(16'h0000);
      expect_mem(1'b1, 8'h41, 16'h0000, 1'b1, 0);
      run(7, "restart");

      // opcode 13 targeting r6 must not write it
      clr();
      put(mvi(4'd6, 8'h07));
      put(enc(4'd13, 4'd6, 4'd0, 4'd0));
      put(mvi(4'd4, 8'h50));
      put(enc(4'd6, 4'd0, 4'd6, 4'd0));
      put(16'h0000);
      expect_mem(1'b1, 8'h50, 16'h0007, 1'b1, 0);
      run(11, "illegal_op");
      chk("illegal_set", illegal, 1'b1);

      clr();
      put(16'h0000);
      run(2, "end_only");
      chk("illegal_cleared", illegal, 1'b0);
      chk("end_only_pc", iram_addr, 0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
